// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage: control bundle,
// forwarding selects, ALU opcodes, branch funct3 codes and FSM states.
package ex_pkg;

  typedef struct packed {
    logic reg_reg;
    logic load;
    logic store;
    logic branch;
  } ex_ctrl_t;

  typedef enum logic [1:0] {
    FWD_ID     = 2'd0,
    FWD_MEM    = 2'd1,
    FWD_WB     = 2'd2,
    FWD_ID_ALT = 2'd3
  } fwd_sel_e;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } ex_state_e;

  localparam logic [3:0] ALU_OP_ADD  = 4'h0;
  localparam logic [3:0] ALU_OP_SUB  = 4'h1;
  localparam logic [3:0] ALU_OP_SLL  = 4'h2;
  localparam logic [3:0] ALU_OP_SLT  = 4'h3;
  localparam logic [3:0] ALU_OP_SLTU = 4'h4;
  localparam logic [3:0] ALU_OP_XOR  = 4'h5;
  localparam logic [3:0] ALU_OP_SRL  = 4'h6;
  localparam logic [3:0] ALU_OP_SRA  = 4'h7;
  localparam logic [3:0] ALU_OP_OR   = 4'h8;
  localparam logic [3:0] ALU_OP_AND  = 4'h9;
  localparam logic [3:0] ALU_OP_LUI  = 4'hA;  // passes operand B through
  localparam logic [3:0] ALU_OP_NOR  = 4'hB;
  localparam logic [3:0] ALU_OP_ANDN = 4'hC;
  localparam logic [3:0] ALU_OP_SEQ  = 4'hD;
  localparam logic [3:0] ALU_OP_SNE  = 4'hE;
  localparam logic [3:0] ALU_OP_MUL  = 4'hF;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/ex_mul_seq.sv
// Iterative shift-add multiplier (low XLEN bits), one partial product per
// cycle; used by execute_unit only when EX_MUL_EN is defined.
module ex_mul_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [XLEN-1:0] acc_sum;

  // The final step's sum is presented combinationally so the caller can
  // capture the product in the same cycle the counter reaches zero.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign busy    = busy_q;
  assign done    = busy_q & (cnt_q == '0);
  assign result  = acc_sum;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (kill) begin
      busy_d = 1'b0;
    end else if (start) begin
      busy_d   = 1'b1;
      cnt_d    = CW'(XLEN - 1);
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
    end else if (busy_q) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      if (cnt_q == '0) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/execute_unit.sv
// Pipeline execute stage: forwarding, ALU, branch compare and target, with a
// single-entry output register. Define EX_MUL_EN for the iterative multiplier.
module execute_unit
  import ex_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int FWD_EN = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ir,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [XLEN-1:0] in_imm,
  input  logic [3:0]      in_alu_op,
  input  ex_ctrl_t        in_ctrl,
  input  logic [1:0]      fwd_a_sel,
  input  logic [1:0]      fwd_b_sel,
  input  logic [XLEN-1:0] mem_fwd,
  input  logic [XLEN-1:0] wb_fwd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_ir,
  output logic            out_cond,
  output logic [XLEN-1:0] out_alu,
  output logic [XLEN-1:0] out_b,
  output logic [XLEN-1:0] out_target
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] op_a, fwd_b, alu_b, alu_res, s_imm;
  logic            cond, accept;
  logic            unused_load;

  ex_state_e       state_q, state_d;
  logic            out_valid_q, out_valid_d, out_cond_q, out_cond_d;
  logic [31:0]     out_ir_q, out_ir_d;
  logic [XLEN-1:0] out_alu_q, out_alu_d, out_b_q, out_b_d, out_target_q, out_target_d;

  assign unused_load = in_ctrl.load;
  assign s_imm       = {{(XLEN-12){in_ir[31]}}, in_ir[31:25], in_ir[11:7]};

  always_comb begin
    op_a  = in_a;
    fwd_b = in_b;
    if (FWD_EN != 0) begin
      case (fwd_sel_e'(fwd_a_sel))
        FWD_MEM: op_a = mem_fwd;
        FWD_WB:  op_a = wb_fwd;
        default: op_a = in_a;
      endcase
      case (fwd_sel_e'(fwd_b_sel))
        FWD_MEM: fwd_b = mem_fwd;
        FWD_WB:  fwd_b = wb_fwd;
        default: fwd_b = in_b;
      endcase
    end
    if (in_ctrl.reg_reg)    alu_b = fwd_b;
    else if (in_ctrl.store) alu_b = s_imm;
    else                    alu_b = in_imm;
  end

  always_comb begin
    case (in_alu_op)
      ALU_OP_ADD:  alu_res = op_a + alu_b;
      ALU_OP_SUB:  alu_res = op_a - alu_b;
      ALU_OP_SLL:  alu_res = op_a << alu_b[SHW-1:0];
      ALU_OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(alu_b)};
      ALU_OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < alu_b};
      ALU_OP_XOR:  alu_res = op_a ^ alu_b;
      ALU_OP_SRL:  alu_res = op_a >> alu_b[SHW-1:0];
      ALU_OP_SRA:  alu_res = $unsigned($signed(op_a) >>> alu_b[SHW-1:0]);
      ALU_OP_OR:   alu_res = op_a | alu_b;
      ALU_OP_AND:  alu_res = op_a & alu_b;
      ALU_OP_LUI:  alu_res = alu_b;
      ALU_OP_NOR:  alu_res = ~(op_a | alu_b);
      ALU_OP_ANDN: alu_res = op_a & ~alu_b;
      ALU_OP_SEQ:  alu_res = {{(XLEN-1){1'b0}}, op_a == alu_b};
      ALU_OP_SNE:  alu_res = {{(XLEN-1){1'b0}}, op_a != alu_b};
      default:     alu_res = '0;  // MUL yields zero unless the multiplier is built
    endcase
  end

  // Branches always compare the forwarded register operands, never the immediate.
  always_comb begin
    cond = 1'b0;
    if (in_ctrl.branch) begin
      case (in_ir[14:12])
        F3_BEQ:  cond = (op_a == fwd_b);
        F3_BNE:  cond = (op_a != fwd_b);
        F3_BLT:  cond = ($signed(op_a) <  $signed(fwd_b));
        F3_BGE:  cond = ($signed(op_a) >= $signed(fwd_b));
        F3_BLTU: cond = (op_a <  fwd_b);
        F3_BGEU: cond = (op_a >= fwd_b);
        default: cond = 1'b0;
      endcase
    end
  end

`ifdef EX_MUL_EN
  logic            mul_start, mul_done, mul_busy_unused;
  logic [XLEN-1:0] mul_result;

  ex_mul_seq #(.XLEN(XLEN)) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start),
    .kill   (flush),
    .a      (op_a),
    .b      (alu_b),
    .busy   (mul_busy_unused),
    .done   (mul_done),
    .result (mul_result)
  );
`endif

  assign in_ready = (~out_valid_q | out_ready) & (state_q == IDLE);
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_ir_d     = out_ir_q;
    out_cond_d   = out_cond_q;
    out_alu_d    = out_alu_q;
    out_b_d      = out_b_q;
    out_target_d = out_target_q;
`ifdef EX_MUL_EN
    mul_start    = 1'b0;
`endif
    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = IDLE;
    end else if (state_q == MUL_BUSY) begin
`ifdef EX_MUL_EN
      if (mul_done) begin
        out_alu_d   = mul_result;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
`endif
    end else if (accept) begin
      out_ir_d     = in_ir;
      out_cond_d   = cond;
      out_alu_d    = alu_res;
      out_b_d      = fwd_b;
      out_target_d = in_pc + in_imm;
      out_valid_d  = 1'b1;
`ifdef EX_MUL_EN
      // Side fields are parked now; valid rises only when the product lands.
      if (in_alu_op == ALU_OP_MUL) begin
        out_valid_d = 1'b0;
        mul_start   = 1'b1;
        state_d     = MUL_BUSY;
      end
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      out_ir_q     <= '0;
      out_cond_q   <= 1'b0;
      out_alu_q    <= '0;
      out_b_q      <= '0;
      out_target_q <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_ir_q     <= out_ir_d;
      out_cond_q   <= out_cond_d;
      out_alu_q    <= out_alu_d;
      out_b_q      <= out_b_d;
      out_target_q <= out_target_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_ir     = out_ir_q;
  assign out_cond   = out_cond_q;
  assign out_alu    = out_alu_q;
  assign out_b      = out_b_q;
  assign out_target = out_target_q;

endmodule

// File: tb/tb_execute_unit.sv
// Self-checking bench for execute_unit: cycle-level reference model plus
// directed vectors with literal expectations (MUL checks depend on EX_MUL_EN).
module tb_execute_unit;
  import ex_pkg::*;

  localparam int XLEN = 32;
`ifdef EX_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  localparam ex_ctrl_t C_NONE   = 4'b0000;
  localparam ex_ctrl_t C_RR     = 4'b1000;
  localparam ex_ctrl_t C_STORE  = 4'b0010;
  localparam ex_ctrl_t C_BRANCH = 4'b1001;

  logic            clk, reset, in_valid, in_ready, flush, out_valid, out_ready, out_cond;
  logic [31:0]     in_ir, out_ir;
  logic [XLEN-1:0] in_pc, in_a, in_b, in_imm, mem_fwd, wb_fwd, out_alu, out_b, out_target;
  logic [3:0]      in_alu_op;
  ex_ctrl_t        in_ctrl;
  logic [1:0]      fwd_a_sel, fwd_b_sel;

  execute_unit #(.XLEN(XLEN), .FWD_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ir(in_ir), .in_pc(in_pc), .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
    .in_alu_op(in_alu_op), .in_ctrl(in_ctrl), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mem_fwd(mem_fwd), .wb_fwd(wb_fwd), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_ir(out_ir), .out_cond(out_cond), .out_alu(out_alu),
    .out_b(out_b), .out_target(out_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit              m_valid = 1'b0;
  bit              m_cond = 1'b0;
  bit              run_cmp = 1'b0;
  int              m_busy = 0;
  logic [31:0]     m_ir = '0;
  logic [XLEN-1:0] m_alu = '0, m_b = '0, m_target = '0, m_prod = '0;

  function automatic logic [XLEN-1:0] pick(input logic [1:0] sel, input logic [XLEN-1:0] id_v);
    if (sel == 2'd1) return mem_fwd;
    if (sel == 2'd2) return wb_fwd;
    return id_v;
  endfunction

  function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    int sh;
    sh = int'(b % XLEN);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << sh;
      4'd3:  return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd4:  return (a < b) ? 1 : 0;
      4'd5:  return a ^ b;
      4'd6:  return a >> sh;
      4'd7:  return $unsigned($signed(a) >>> sh);
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      4'd11: return ~(a | b);
      4'd12: return a & ~b;
      4'd13: return (a == b) ? 1 : 0;
      4'd14: return (a != b) ? 1 : 0;
      default: return '0;
    endcase
  endfunction

  function automatic bit ref_cond(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    case (f3)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return $signed(a) < $signed(b);
      3'b101: return $signed(a) >= $signed(b);
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    bit              rdy;
    int              simm;
    logic [XLEN-1:0] a, bf, bal;
    rdy = (!m_valid || out_ready) && (m_busy == 0);
    if (reset) begin
      m_valid = 0; m_busy = 0; m_ir = '0; m_cond = 0; m_alu = '0; m_b = '0; m_target = '0;
      run_cmp = 1'b1;
    end else if (flush) begin
      m_valid = 0; m_busy = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_valid = 1;
        m_alu   = m_prod;
      end
    end else if (in_valid && rdy) begin
      a  = pick(fwd_a_sel, in_a);
      bf = pick(fwd_b_sel, in_b);
      simm = int'({in_ir[31:25], in_ir[11:7]});
      if (simm >= 2048) simm -= 4096;
      if (in_ctrl.reg_reg)    bal = bf;
      else if (in_ctrl.store) bal = XLEN'(simm);
      else                    bal = in_imm;
      m_ir     = in_ir;
      m_alu    = ref_alu(in_alu_op, a, bal);
      m_cond   = in_ctrl.branch ? ref_cond(in_ir[14:12], a, bf) : 1'b0;
      m_b      = bf;
      m_target = in_pc + in_imm;
      m_valid  = 1;
      if (MUL_EN && in_alu_op == 4'hF) begin
        m_prod  = a * bal;
        m_busy  = XLEN;
        m_valid = 0;
      end
      $display("issue ir=0x%08h op=%0d a=0x%0h b=0x%0h -> alu=0x%0h cond=%0d", in_ir, in_alu_op, a, bal, m_alu, m_cond);
    end else if (out_ready) begin
      m_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      check("cmp_in_ready", in_ready, (!m_valid || out_ready) && (m_busy == 0));
      check("cmp_out_valid", out_valid, m_valid);
      if (m_valid) begin
        check("cmp_out_ir", out_ir, m_ir);
        check("cmp_out_alu", out_alu, m_alu);
        check("cmp_out_cond", out_cond, m_cond);
        check("cmp_out_b", out_b, m_b);
        check("cmp_out_target", out_target, m_target);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] ir, input logic [3:0] op, input ex_ctrl_t c,
                        input logic [XLEN-1:0] pc, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] imm, input logic [1:0] fa, input logic [1:0] fb);
    in_ir = ir; in_alu_op = op; in_ctrl = c; in_pc = pc; in_a = a; in_b = b;
    in_imm = imm; fwd_a_sel = fa; fwd_b_sel = fb; in_valid = 1'b1;
  endtask

  task automatic issue(input logic [31:0] ir, input logic [3:0] op, input ex_ctrl_t c,
                       input logic [XLEN-1:0] pc, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] imm, input logic [1:0] fa, input logic [1:0] fb);
    set_in(ir, op, c, pc, a, b, imm, fa, fb);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    step();
  endtask

  localparam logic [31:0] IR_ST   = {7'h7F, 5'd2, 5'd1, 3'b010, 5'h1C, 7'b0100011};
  localparam logic [31:0] IR_BLT  = {7'h00, 5'd2, 5'd1, 3'b100, 5'h00, 7'b1100011};
  localparam logic [31:0] IR_BLTU = {7'h00, 5'd2, 5'd1, 3'b110, 5'h00, 7'b1100011};

  logic [XLEN-1:0] sweep_a [4];
  logic [XLEN-1:0] sweep_b [4];

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_ir = '0; in_pc = '0; in_a = '0; in_b = '0; in_imm = '0; in_alu_op = '0;
    in_ctrl = C_NONE; fwd_a_sel = '0; fwd_b_sel = '0;
    mem_fwd = 32'h55; wb_fwd = 32'h1234_5678;
    sweep_a = '{32'h8000_0001, 32'h0000_1234, 32'hFFFF_FFF0, 32'h0000_0007};
    sweep_b = '{32'h0000_0003, 32'h0000_1234, 32'h0000_0004, 32'hFFFF_FFFF};

    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ir", out_ir, 0);
    check("rst_out_cond", out_cond, 0);
    check("rst_out_alu", out_alu, 0);
    check("rst_out_b", out_b, 0);
    check("rst_out_target", out_target, 0);
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1);

    issue(32'h0000_0033, ALU_OP_ADD, C_RR, 0, 5, 7, 0, 2'd0, 2'd0);
    check("add_valid", out_valid, 1);
    check("add_alu", out_alu, 12);

    issue(IR_ST, ALU_OP_ADD, C_STORE, 0, 32'h100, 32'hDEAD_BEEF, 32'h999, 2'd0, 2'd0);
    check("st_alu", out_alu, 32'hFC);
    check("st_b", out_b, 32'hDEAD_BEEF);
    issue(IR_ST, ALU_OP_ADD, C_STORE, 0, 32'h100, 32'hDEAD_BEEF, 32'h999, 2'd0, 2'd2);
    check("st_b_wbfwd", out_b, 32'h1234_5678);

    issue(IR_BLT, ALU_OP_SUB, C_BRANCH, 32'h40, 32'hFFFF_FFFF, 1, 32'hFFFF_FFF8, 2'd0, 2'd0);
    check("blt_cond", out_cond, 1);
    check("blt_target", out_target, 32'h38);
    issue(IR_BLTU, ALU_OP_SUB, C_BRANCH, 32'h40, 32'hFFFF_FFFF, 1, 32'hFFFF_FFF8, 2'd0, 2'd0);
    check("bltu_cond", out_cond, 0);
    for (int f = 0; f < 8; f++) begin
      issue({17'h0, 3'(f), 5'h0, 7'b1100011}, ALU_OP_SUB, C_BRANCH, 32'h100, 32'h5, 32'h5, 32'h20, 2'd0, 2'd0);
    end

    issue(32'h0010_0013, ALU_OP_ADD, C_NONE, 0, 0, 0, 1, 2'd1, 2'd0);
    check("fwd_mem_alu", out_alu, 32'h56);
    issue(32'h0010_0013, ALU_OP_ADD, C_RR, 0, 9, 9, 0, 2'd3, 2'd2);

    for (int p = 0; p < 4; p++) begin
      for (int op = 0; op < 15; op++) begin
        issue({20'h0, 4'(op), 8'h33}, 4'(op), C_RR, 32'(p * 4), sweep_a[p], sweep_b[p], 0, 2'd0, 2'(p % 3));
      end
    end

    // Backpressure: hold the result for three cycles, then stream back to back.
    drain();
    out_ready = 1'b0;
    issue(32'hA0A0_0033, ALU_OP_ADD, C_RR, 0, 1, 2, 0, 2'd0, 2'd0);
    set_in(32'hB0B0_0033, ALU_OP_XOR, C_RR, 0, 32'hF0, 32'h0F, 0, 2'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", in_ready, 0);
      check("stall_out_ir", out_ir, 32'hA0A0_0033);
      check("stall_out_alu", out_alu, 3);
      step();
    end
    out_ready = 1'b1;
    step();
    check("b2b_ir_b", out_ir, 32'hB0B0_0033);
    check("b2b_alu_b", out_alu, 32'hFF);
    set_in(32'hC0C0_0033, ALU_OP_SUB, C_RR, 0, 10, 3, 0, 2'd0, 2'd0);
    step();
    check("b2b_ir_c", out_ir, 32'hC0C0_0033);
    check("b2b_alu_c", out_alu, 7);
    in_valid = 1'b0;

    // Flush kills both a same-cycle accept and a stalled result.
    drain();
    set_in(32'hDEAD_0033, ALU_OP_ADD, C_RR, 0, 1, 1, 0, 2'd0, 2'd0);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_accept_valid", out_valid, 0);
    out_ready = 1'b0;
    issue(32'hE0E0_0033, ALU_OP_ADD, C_RR, 0, 1, 1, 0, 2'd0, 2'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_stalled_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    drain();

`ifdef EX_MUL_EN
    issue(32'h0220_80B3, ALU_OP_MUL, C_RR, 0, 6, 7, 0, 2'd0, 2'd0);
    check("mul_busy_ready", in_ready, 0);
    for (int i = 0; i < XLEN - 1; i++) step();
    check("mul_not_yet_valid", out_valid, 0);
    step();
    check("mul_valid", out_valid, 1);
    check("mul_alu", out_alu, 42);
    drain();
    issue(32'h0220_80B3, ALU_OP_MUL, C_RR, 0, 3, 5, 0, 2'd0, 2'd0);
    for (int i = 0; i < 9; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("mul_flush_valid", out_valid, 0);
    check("mul_flush_ready", in_ready, 1);
    for (int i = 0; i < XLEN + 2; i++) step();
    issue(32'h0220_80B3, ALU_OP_MUL, C_RR, 0, 32'h1_0001, 32'h1_0001, 0, 2'd0, 2'd0);
    for (int i = 0; i < XLEN; i++) step();
    check("mul_wrap_alu", out_alu, 32'h0002_0001);
`else
    issue(32'h0220_80B3, ALU_OP_MUL, C_RR, 0, 6, 7, 0, 2'd0, 2'd0);
    check("mul_off_valid", out_valid, 1);
    check("mul_off_alu", out_alu, 0);
`endif

    drain();
    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
